cfg_write_arbiter: RTL

//  Shares the 5-entry PWM/output-enable config register bank between N_REQ write requesters.

---
 rtl/cfg_write_arbiter_pkg.sv | 23 ++
 rtl/cfg_write_arbiter_if.sv | 17 +
 rtl/cfg_write_arbiter_rr_arbiter.sv | 41 ++++
 rtl/cfg_write_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/cfg_write_arbiter_pkg.sv
// Shared constants and types for the config-register write arbiter:
// register addresses, bank type and the address range check.
package cfg_pkg;

    localparam int ADDR_W       = 7;
    localparam int DATA_W       = 8;
    localparam int NUM_CFG_REGS = 5;
    localparam int CFG_IDX_W    = 3;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
    localparam logic [ADDR_W-1:0] MAX_CFG_ADDR   = 7'h04;

    typedef logic [NUM_CFG_REGS-1:0][DATA_W-1:0] cfg_bank_t;

    function automatic logic addr_in_bank(input logic [ADDR_W-1:0] addr);
        return addr <= MAX_CFG_ADDR;
    endfunction

endpackage

// File: rtl/cfg_write_arbiter_if.sv
// Write-request bundle for N_REQ requesters; requester i owns the i-th
// addr/data slice and the i-th valid/ready bit.
interface cfg_write_arbiter_if
    import cfg_pkg::*;
#(
    parameter int N_REQ = 2
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/cfg_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or
// after the pointer; the pointer moves past the winner when 'advance' is set.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && valid[(int'(ptr_q) + i) % N]) begin
                grant[(int'(ptr_q) + i) % N] = 1'b1;
                grant_idx = IDX_W'((int'(ptr_q) + i) % N);
                found     = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Shares the 5-entry PWM/output-enable register bank between N_REQ writers,
// with optional shadow buffering committed at PWM period boundaries.
module cfg_write_arbiter
    import cfg_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_write_arbiter_if.slave   bus,
    input  logic                 shadow_en,
    input  logic                 commit_strobe,
    output logic [DATA_W-1:0]    en_reg_out_7_0,
    output logic [DATA_W-1:0]    en_reg_out_15_8,
    output logic [DATA_W-1:0]    en_reg_pwm_7_0,
    output logic [DATA_W-1:0]    en_reg_pwm_15_8,
    output logic [DATA_W-1:0]    pwm_duty_cycle,
    output logic                 pending,
    output logic                 wr_err,
    output logic [ERR_W-1:0]     err_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 xfer;
    logic                 addr_ok;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [CFG_IDX_W-1:0] wr_idx;
    cfg_bank_t            shadow_q;
    cfg_bank_t            live_q;
    cfg_bank_t            shadow_nxt;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (bus.req_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is held low while in reset so nothing is acknowledged then.
    assign bus.req_ready = rst ? '0 : grant;
    assign xfer    = |(bus.req_valid & bus.req_ready);
    assign wr_addr = bus.req_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
    assign wr_data = bus.req_data[DATA_W*int'(grant_idx) +: DATA_W];
    assign addr_ok = addr_in_bank(wr_addr);
    assign wr_idx  = wr_addr[CFG_IDX_W-1:0];

    // The shadow view including this cycle's write, so a same-cycle commit merges it.
    always_comb begin
        shadow_nxt = shadow_q;
        if (xfer && addr_ok) shadow_nxt[wr_idx] = wr_data;
    end

    // NOTE: the bank is reset because it drives live PWM/enable pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            live_q    <= '0;
            pending   <= 1'b0;
            wr_err    <= 1'b0;
            err_count <= '0;
        end else begin
            shadow_q <= shadow_nxt;
            wr_err   <= xfer && !addr_ok;
            if (shadow_en) begin
                if (commit_strobe) begin
                    live_q  <= shadow_nxt;
                    pending <= 1'b0;
                end else if (xfer && addr_ok) begin
                    pending <= 1'b1;
                end
            end else if (xfer && addr_ok) begin
                live_q[wr_idx] <= wr_data;
            end
            if (xfer && !addr_ok && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign en_reg_out_7_0  = live_q[ADDR_EN_OUT_LO[CFG_IDX_W-1:0]];
    assign en_reg_out_15_8 = live_q[ADDR_EN_OUT_HI[CFG_IDX_W-1:0]];
    assign en_reg_pwm_7_0  = live_q[ADDR_EN_PWM_LO[CFG_IDX_W-1:0]];
    assign en_reg_pwm_15_8 = live_q[ADDR_EN_PWM_HI[CFG_IDX_W-1:0]];
    assign pwm_duty_cycle  = live_q[ADDR_DUTY[CFG_IDX_W-1:0]];

endmodule
